rv32_fetch_unit: RTL and testbench
==================================

# rv32_fetch_unit

Instruction fetch stage of the multicycle RV32 core. Holds the fetch PC, issues single-outstanding word reads on the instruction memory req/gnt/rvalid bus, and presents {pc, instr, fault} to the downstream skid buffer through a valid/ready handshake. Accepts redirects (branch, jump, trap) from the execute stage, discards in-flight responses, and converts misaligned targets and bus errors into fault entries.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- NOP_INSTR, 32'h0000_0013, instruction word driven on fault entries and at reset

- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_redirect_valid  in  1  replace fetch PC (one-cycle pulse)
- i_redirect_pc  in  32  new fetch PC
- o_imem_req  out  1  read request
- o_imem_addr  out  32  word address (byte address, bits [1:0]=0)
- i_imem_gnt  in  1  request accepted this cycle
- i_imem_rvalid  in  1  response valid
- i_imem_rdata  in  32  response data
- i_imem_err  in  1  response is an access error (qualified by rvalid)
- o_valid_send  out  1  output entry valid
- o_pc  out  32  PC of entry
- o_instr  out  32  instruction of entry
- o_fault  out  1  entry is a fetch fault (misaligned or access error)
- i_ready_send  in  1  downstream accepts entry

## Operation
- States: IDLE, REQ, WAIT, HOLD, DRAIN, HALT. All outputs registered; o_imem_req = (state==REQ), o_imem_addr = pc register.
- IDLE: one cycle after reset release, then REQ.
- REQ: hold req/addr until gnt; on gnt -> WAIT.
- WAIT: on rvalid: capture o_pc=pc, o_instr=rdata (NOP_INSTR if err), o_fault=err, o_valid_send=1 -> HOLD.
- HOLD: entry stable while !i_ready_send. On ready: o_valid_send=0; if o_fault -> HALT, else pc<=pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0) -> REQ.
- HALT: no fetching; waits for redirect.
- Redirect (highest priority, any state), pc<=i_redirect_pc, o_valid_send<=0 (entry dropped even if ready same cycle):
  - misaligned target (bits [1:0]!=0): no bus access; next cycle o_valid_send=1, o_fault=1, o_pc=target, o_instr=NOP_INSTR -> HOLD; if a request is outstanding, go DRAIN first and emit the fault after the drain.
  - aligned, no request outstanding (IDLE, REQ without gnt, HOLD, HALT) -> REQ. Request withdrawn in REQ without gnt: address changes next cycle (only permitted address change).
  - request outstanding (WAIT without rvalid, or REQ with gnt same cycle) -> DRAIN.
  - WAIT with rvalid same cycle: response discarded -> REQ.
- DRAIN: discard next rvalid (data and err), then REQ (or fault entry if target misaligned). Further redirects in DRAIN update pc only.
- Never more than one outstanding request.

## Timing
- Reset values: o_imem_req=0, o_imem_addr=RESET_PC, o_valid_send=0, o_pc=RESET_PC, o_instr=NOP_INSTR, o_fault=0; state IDLE. Reset mid-transaction abandons it; a later stray rvalid is ignored in IDLE/REQ.
- First o_imem_req: 2nd cycle after i_rst deasserts.
- Latency with 0-wait memory (gnt same cycle as req, rvalid one cycle later): req at T, rvalid T+1, o_valid_send T+2; if ready at T+2, next req at T+3. Throughput 1 instr / 3 cycles.
- rvalid earliest one cycle after gnt; rvalid outside WAIT/DRAIN ignored.
- Redirect effective on the next edge: new address on o_imem_addr the cycle after the pulse (when no drain).

## Test plan
- Reset with RESET_PC=32'h100, 0-wait memory returning addr^32'hA5A5_0000, ready=1 -> entries pc 0x100,0x104,0x108 with matching instr, req every 3 cycles.
- Downstream backpressure: ready=0 for 5 cycles on entry 0x104 -> o_pc/o_instr stable, o_imem_req=0, fetch 0x108 begins cycle after ready.
- Redirect to 0x200 one cycle after gnt for 0x104, rvalid 2 cycles later -> 0x104 response dropped, next req addr 0x200, first entry pc 0x200.
- Redirect to 0x302 while HOLD -> entry dropped, fault entry pc 0x302, instr 0x13, fault=1, no bus request; HALT until redirect to 0x400 resumes fetch at 0x400.
- rvalid with err=1 for 0x10C -> entry pc 0x10C fault=1 instr 0x13, then no requests until redirect.
- Gnt held low 4 cycles -> req/addr stable; PC at 32'hFFFF_FFFC, ready -> next addr 0x0.

Source files
------------

// File: rtl/rv32_fetch_unit_if.sv
// rtl/rv32_fetch_unit_if.sv - fetch unit redirect, instruction memory and downstream entry signals
interface rv32_fetch_unit_if;
    logic        i_redirect_valid;
    logic [31:0] i_redirect_pc;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_gnt;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        i_imem_err;
    logic        o_valid_send;
    logic [31:0] o_pc;
    logic [31:0] o_instr;
    logic        o_fault;
    logic        i_ready_send;

    modport master (
        input  i_redirect_valid, i_redirect_pc,
        output o_imem_req, o_imem_addr,
        input  i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_imem_err,
        output o_valid_send, o_pc, o_instr, o_fault,
        input  i_ready_send
    );

    modport slave (
        output i_redirect_valid, i_redirect_pc,
        input  o_imem_req, o_imem_addr,
        output i_imem_gnt, i_imem_rvalid, i_imem_rdata, i_imem_err,
        input  o_valid_send, o_pc, o_instr, o_fault,
        output i_ready_send
    );
endinterface

// File: rtl/rv32_fetch_unit.sv
// rtl/rv32_fetch_unit.sv - RV32 fetch stage: single-outstanding imem reads, redirects, fault entries
module rv32_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic              i_clk,
    input  logic              i_rst,
    rv32_fetch_unit_if.master bus
);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic [31:0] drain_tgt;
    logic        outstanding;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            out_pc_q <= RESET_PC;
            instr_q  <= NOP_INSTR;
            valid_q  <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            out_pc_q <= out_pc_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            fault_q  <= fault_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        out_pc_d = out_pc_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        fault_d  = fault_q;
        // A redirect arriving during a drain retargets the pending exit.
        drain_tgt   = bus.i_redirect_valid ? bus.i_redirect_pc : pc_q;
        outstanding = ((state_q == WAIT) && !bus.i_imem_rvalid) ||
                      ((state_q == REQ) && bus.i_imem_gnt);

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (bus.i_imem_gnt) state_d = WAIT;
            end
            WAIT: begin
                if (bus.i_imem_rvalid) begin
                    valid_d  = 1'b1;
                    out_pc_d = pc_q;
                    instr_d  = bus.i_imem_err ? NOP_INSTR : bus.i_imem_rdata;
                    fault_d  = bus.i_imem_err;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (bus.i_ready_send) begin
                    valid_d = 1'b0;
                    if (fault_q) begin
                        state_d = HALT;
                    end else begin
                        pc_d    = pc_q + 32'd4;
                        state_d = REQ;
                    end
                end
            end
            DRAIN: begin
                pc_d = drain_tgt;
                if (bus.i_imem_rvalid) begin
                    if (drain_tgt[1:0] != 2'b00) begin
                        valid_d  = 1'b1;
                        fault_d  = 1'b1;
                        out_pc_d = drain_tgt;
                        instr_d  = NOP_INSTR;
                        state_d  = HOLD;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase

        if (bus.i_redirect_valid && (state_q != DRAIN)) begin
            pc_d    = bus.i_redirect_pc;
            valid_d = 1'b0;
            if (outstanding) begin
                state_d = DRAIN;
            end else if (bus.i_redirect_pc[1:0] != 2'b00) begin
                // Misaligned target never reaches the bus; it becomes a fault entry.
                valid_d  = 1'b1;
                fault_d  = 1'b1;
                out_pc_d = bus.i_redirect_pc;
                instr_d  = NOP_INSTR;
                state_d  = HOLD;
            end else begin
                state_d = REQ;
            end
        end
    end

    assign bus.o_imem_req   = (state_q == REQ);
    assign bus.o_imem_addr  = pc_q;
    assign bus.o_valid_send = valid_q;
    assign bus.o_pc         = out_pc_q;
    assign bus.o_instr      = instr_q;
    assign bus.o_fault      = fault_q;

endmodule

// File: tb/tb_rv32_fetch_unit.sv
// tb/tb_rv32_fetch_unit.sv - randomized scoreboard bench for rv32_fetch_unit
module tb_rv32_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0100;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    rv32_fetch_unit_if bus();

    rv32_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int acc_cnt = 0;

    int gnt_prob = 100;
    int ready_prob = 100;
    int lat_min = 0;
    int lat_max = 0;
    int stall_left = 5;
    logic [31:0] stall_pc = 32'h104;
    logic [31:0] err_addr = 32'h10C;
    bit err_rand = 1'b0;
    bit zw = 1'b1;

    bit mem_pend = 1'b0;
    int mem_cnt = 0;
    logic [31:0] mem_addr = '0;

    ent_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit errfn(input logic [31:0] a);
        return (a == err_addr) || (err_rand && (a[7:2] == 6'd13));
    endfunction

    // Program-order view: each fetched word is its own address scrambled, faults carry NOP.
    function automatic ent_t ent(input logic [31:0] a);
        ent_t e;
        e.pc    = a;
        e.fault = (a[1:0] != 2'b00) || errfn(a);
        e.instr = e.fault ? NOP_INSTR : (a ^ 32'hA5A5_0000);
        return e;
    endfunction

    // Memory and downstream responder.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            bus.i_imem_gnt    = 1'b0;
            bus.i_imem_rvalid = 1'b0;
            bus.i_imem_err    = 1'b0;
            bus.i_imem_rdata  = '0;
            bus.i_ready_send  = 1'b0;
            mem_pend          = 1'b0;
        end else begin
            bus.i_imem_rvalid = 1'b0;
            bus.i_imem_err    = 1'b0;
            bus.i_imem_rdata  = $urandom;
            if (mem_pend) begin
                if (mem_cnt == 0) begin
                    bus.i_imem_rvalid = 1'b1;
                    bus.i_imem_rdata  = mem_addr ^ 32'hA5A5_0000;
                    bus.i_imem_err    = errfn(mem_addr);
                    mem_pend          = 1'b0;
                end else begin
                    mem_cnt--;
                end
            end
            bus.i_imem_gnt = 1'b0;
            if (bus.o_imem_req && !mem_pend && ($urandom_range(99) < gnt_prob)) begin
                bus.i_imem_gnt = 1'b1;
                mem_pend       = 1'b1;
                mem_addr       = bus.o_imem_addr;
                mem_cnt        = $urandom_range(lat_max, lat_min);
            end
            if (stall_left > 0 && bus.o_valid_send && bus.o_pc == stall_pc) begin
                bus.i_ready_send = 1'b0;
                stall_left--;
            end else begin
                bus.i_ready_send = ($urandom_range(99) < ready_prob);
            end
        end
    end

    logic        p_req_nogrant, p_redir, p_valid, p_ready, p_fault, p_acc_ok;
    logic [31:0] p_addr, p_pc, p_instr;
    logic        g1, g2, r1, r2;

    // Monitor and scoreboard.
    always @(negedge clk) begin
        ent_t e;
        logic acc_now;
        if (rst) begin
            exp_q.delete();
            exp_q.push_back(ent(RESET_PC));
            {p_req_nogrant, p_redir, p_valid, p_ready, p_fault, p_acc_ok} = '0;
            {g1, g2, r1, r2} = '0;
            p_addr = '0; p_pc = '0; p_instr = '0;
        end else begin
            acc_now = 1'b0;
            chk("single_outstanding", bus.o_imem_req && mem_pend && !bus.i_imem_gnt, 1'b0);
            chk("valid_excludes_req", bus.o_valid_send && bus.o_imem_req, 1'b0);
            if (bus.o_imem_req) chk("addr_aligned", bus.o_imem_addr[1:0], 2'b00);
            if (p_req_nogrant && !p_redir) begin
                chk("req_held", bus.o_imem_req, 1'b1);
                chk("addr_held", bus.o_imem_addr, p_addr);
            end
            if (p_acc_ok) chk("refetch_after_accept", bus.o_imem_req, 1'b1);
            if (p_valid && !p_ready && !p_redir) begin
                chk("hold_valid", bus.o_valid_send, 1'b1);
                chk("hold_pc", bus.o_pc, p_pc);
                chk("hold_instr", bus.o_instr, p_instr);
                chk("hold_fault", bus.o_fault, p_fault);
            end
            if (exp_q.size() == 0) begin
                chk("halt_no_req", bus.o_imem_req, 1'b0);
                chk("halt_no_valid", bus.o_valid_send, 1'b0);
            end
            if (zw && g2 && !r1 && !r2) chk("zero_wait_latency", bus.o_valid_send, 1'b1);

            if (bus.i_redirect_valid) begin
                exp_q.delete();
                exp_q.push_back(ent(bus.i_redirect_pc));
            end else if (bus.o_valid_send && bus.i_ready_send && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("entry_pc", bus.o_pc, e.pc);
                chk("entry_instr", bus.o_instr, e.instr);
                chk("entry_fault", bus.o_fault, e.fault);
                acc_cnt++;
                if (!e.fault) exp_q.push_back(ent(e.pc + 32'd4));
                acc_now = !e.fault;
            end

            p_req_nogrant = bus.o_imem_req && !bus.i_imem_gnt;
            p_addr   = bus.o_imem_addr;
            p_redir  = bus.i_redirect_valid;
            p_valid  = bus.o_valid_send;
            p_ready  = bus.i_ready_send;
            p_pc     = bus.o_pc;
            p_instr  = bus.o_instr;
            p_fault  = bus.o_fault;
            p_acc_ok = acc_now;
            g2 = g1; g1 = bus.o_imem_req && bus.i_imem_gnt;
            r2 = r1; r1 = bus.i_redirect_valid;
        end
    end

    task automatic redirect(input logic [31:0] t);
        @(posedge clk); #1;
        bus.i_redirect_valid = 1'b1;
        bus.i_redirect_pc    = t;
        @(posedge clk); #1;
        bus.i_redirect_valid = 1'b0;
    endtask

    task automatic wait_acc(input int n, input int budget, input string name);
        int k = 0;
        while (acc_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk(name, acc_cnt >= n, 1'b1);
    endtask

    task automatic wait_gnt(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(bus.o_imem_req && bus.i_imem_gnt) && k < budget);
        chk("wait_gnt", bus.o_imem_req && bus.i_imem_gnt, 1'b1);
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.o_valid_send && k < budget);
        chk("wait_valid", bus.o_valid_send, 1'b1);
    endtask

    initial begin
        int base;
        bus.i_redirect_valid = 1'b0;
        bus.i_redirect_pc    = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", bus.o_imem_req, 1'b0);
        chk("rst_addr", bus.o_imem_addr, RESET_PC);
        chk("rst_valid", bus.o_valid_send, 1'b0);
        chk("rst_pc", bus.o_pc, RESET_PC);
        chk("rst_instr", bus.o_instr, NOP_INSTR);
        chk("rst_fault", bus.o_fault, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("first_req", bus.o_imem_req, 1'b1);
        chk("first_addr", bus.o_imem_addr, RESET_PC);

        // Zero-wait run: 0x100..0x108, stall on 0x104, bus error at 0x10C halts.
        wait_acc(4, 200, "zero_wait_entries");
        repeat (5) @(negedge clk);
        zw = 1'b0;
        err_addr = 32'h1;

        // In-flight response dropped by a redirect one cycle after its grant.
        lat_min = 2; lat_max = 2;
        redirect(32'h180);
        wait_gnt(50);
        base = acc_cnt;
        redirect(32'h200);
        wait_acc(base + 1, 100, "redirect_drain_entry");

        // Misaligned redirect while holding an entry, then resume after halt.
        lat_min = 0; lat_max = 1; ready_prob = 0;
        wait_valid(50);
        redirect(32'h302);
        repeat (4) @(negedge clk);
        base = acc_cnt;
        ready_prob = 100;
        wait_acc(base + 1, 50, "misaligned_fault_entry");
        repeat (4) @(negedge clk);
        redirect(32'h400);
        wait_acc(base + 3, 100, "resume_after_halt");

        // Slow grants and address wrap.
        gnt_prob = 20;
        base = acc_cnt;
        redirect(32'hFFFF_FFF4);
        wait_acc(base + 4, 600, "wrap_entries");

        // Randomized traffic with random redirects and bus errors.
        gnt_prob = 70; lat_min = 0; lat_max = 3; ready_prob = 60; err_rand = 1'b1;
        base = acc_cnt;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if ($urandom_range(99) < 4) begin
                bus.i_redirect_valid = 1'b1;
                bus.i_redirect_pc    = ($urandom_range(7) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15)
                                                                : {20'h0, 12'($urandom_range(4095))};
                if ($urandom_range(5) != 0) bus.i_redirect_pc[1:0] = 2'b00;
            end else begin
                bus.i_redirect_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        bus.i_redirect_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("random_progress", (acc_cnt - base) >= 50, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
